// File: rtl/mem_xbar_arb_if.sv
// Master-side request/response bus of the memory crossbar; every master owns one
// packed lane, with master 0 in the least significant bits.
interface mem_xbar_arb_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 30,
   parameter int DATA_WIDTH  = 32
);
   logic [NUM_MASTERS-1:0]              i_m_req;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0]   i_m_addr;
   logic [NUM_MASTERS*DATA_WIDTH-1:0]   i_m_data;
   logic [NUM_MASTERS*DATA_WIDTH/8-1:0] i_m_mask;
   logic [NUM_MASTERS-1:0]              i_m_wren;
   logic [NUM_MASTERS-1:0]              o_m_gnt;
   logic [NUM_MASTERS-1:0]              o_m_rvalid;
   logic                                o_m_err;
   logic [DATA_WIDTH-1:0]               o_m_rdata;

   modport master (
      output i_m_req, i_m_addr, i_m_data, i_m_mask, i_m_wren,
      input  o_m_gnt, o_m_rvalid, o_m_err, o_m_rdata
   );

   modport slave (
      input  i_m_req, i_m_addr, i_m_data, i_m_mask, i_m_wren,
      output o_m_gnt, o_m_rvalid, o_m_err, o_m_rdata
   );
endinterface

// File: rtl/mem_xbar_arb.sv
// Round-robin arbiter routing NUM_MASTERS request ports to data memory, an MMIO
// window, or a decode-error responder, with one transaction in flight at a time.
module mem_xbar_arb #(
   parameter int                    NUM_MASTERS     = 2,
   parameter int                    ADDR_WIDTH      = 30,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    DMEM_ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] DATA_START      = 30'h0,
   parameter logic [ADDR_WIDTH-1:0] DATA_LIMIT      = 30'h3FF,
   parameter logic [ADDR_WIDTH-1:0] MMIO_START      = 30'h4000000,
   parameter logic [ADDR_WIDTH-1:0] MMIO_LIMIT      = 30'h40000FF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   mem_xbar_arb_if.slave              bus,
   output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [DATA_WIDTH-1:0]      o_dmem_data,
   output logic [DATA_WIDTH/8-1:0]    o_dmem_mask,
   output logic                       o_dmem_wren,
   input  logic [DATA_WIDTH-1:0]      i_dmem_data,
   output logic                       o_mmio_req,
   output logic [ADDR_WIDTH-1:0]      o_mmio_addr,
   output logic [DATA_WIDTH-1:0]      o_mmio_data,
   output logic [DATA_WIDTH/8-1:0]    o_mmio_mask,
   output logic                       o_mmio_wren,
   input  logic                       i_mmio_ready,
   input  logic [DATA_WIDTH-1:0]      i_mmio_data
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int ID_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [ADDR_WIDTH-1:0] DATA_SPAN = DATA_LIMIT - DATA_START;
   localparam logic [ADDR_WIDTH-1:0] MMIO_SPAN = MMIO_LIMIT - MMIO_START;

   typedef enum logic [1:0] {IDLE, DMEM_RESP, MMIO_WAIT, ERR_RESP} state_t;

   state_t                  state, state_next;
   logic [ID_WIDTH-1:0]     rr_ptr, lat_id, win_id, cand;
   logic                    win_found;
   logic [ADDR_WIDTH-1:0]   win_addr, data_off, mmio_off, lat_addr;
   logic [DATA_WIDTH-1:0]   win_data, lat_data;
   logic [MASK_WIDTH-1:0]   win_mask, lat_mask;
   logic                    win_wren, lat_wren;
   logic                    in_data, in_mmio;

   // First requester at or above rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_MASTERS);
         if (!win_found && bus.i_m_req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign win_addr = bus.i_m_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_data = bus.i_m_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
   assign win_mask = bus.i_m_mask[int'(win_id)*MASK_WIDTH +: MASK_WIDTH];
   assign win_wren = bus.i_m_wren[win_id];

   // Offset-and-span compare gives inclusive bounds without signed/zero-bound corner cases.
   assign data_off = win_addr - DATA_START;
   assign mmio_off = win_addr - MMIO_START;
   assign in_data  = (data_off <= DATA_SPAN);
   assign in_mmio  = !in_data && (mmio_off <= MMIO_SPAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         lat_id   <= '0;
         lat_addr <= '0;
         lat_data <= '0;
         lat_mask <= '0;
         lat_wren <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && win_found) begin
            lat_id   <= win_id;
            lat_addr <= win_addr;
            lat_data <= win_data;
            lat_mask <= win_mask;
            lat_wren <= win_wren;
            rr_ptr   <= ID_WIDTH'((int'(win_id) + 1) % NUM_MASTERS);
         end
      end
   end

   always_comb begin
      state_next     = state;
      bus.o_m_gnt    = '0;
      bus.o_m_rvalid = '0;
      bus.o_m_err    = 1'b0;
      bus.o_m_rdata  = '0;
      o_dmem_addr    = '0;
      o_dmem_data    = '0;
      o_dmem_mask    = '0;
      o_dmem_wren    = 1'b0;
      o_mmio_req     = 1'b0;
      o_mmio_addr    = '0;
      o_mmio_data    = '0;
      o_mmio_mask    = '0;
      o_mmio_wren    = 1'b0;
      case (state)
         IDLE: begin
            // Grants are held off while reset is asserted so every output reads 0.
            if (win_found && rst_n) begin
               bus.o_m_gnt[win_id] = 1'b1;
               if (in_data) begin
                  o_dmem_addr = data_off[DMEM_ADDR_WIDTH-1:0];
                  o_dmem_data = win_data;
                  o_dmem_mask = win_mask;
                  o_dmem_wren = win_wren;
                  state_next  = DMEM_RESP;
               end else if (in_mmio) begin
                  state_next  = MMIO_WAIT;
               end else begin
                  state_next  = ERR_RESP;
               end
            end
         end
         DMEM_RESP: begin
            bus.o_m_rvalid[lat_id] = 1'b1;
            bus.o_m_rdata          = lat_wren ? '0 : i_dmem_data;
            state_next             = IDLE;
         end
         MMIO_WAIT: begin
            o_mmio_req  = 1'b1;
            o_mmio_addr = lat_addr - MMIO_START;
            o_mmio_data = lat_data;
            o_mmio_mask = lat_mask;
            o_mmio_wren = lat_wren;
            if (i_mmio_ready) begin
               bus.o_m_rvalid[lat_id] = 1'b1;
               bus.o_m_rdata          = lat_wren ? '0 : i_mmio_data;
               state_next             = IDLE;
            end
         end
         ERR_RESP: begin
            bus.o_m_rvalid[lat_id] = 1'b1;
            bus.o_m_err            = 1'b1;
            state_next             = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_xbar_arb.sv
// Testbench for mem_xbar_arb: directed scenarios followed by random traffic, checked
// against a transaction-level model of arbitration order, address decode and memory.
module tb_mem_xbar_arb;

   localparam int NM  = 2;
   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int MW  = 4;
   localparam int DAW = 10;
   localparam logic [AW-1:0] DATA_START = 30'h0;
   localparam logic [AW-1:0] DATA_LIMIT = 30'h3FF;
   localparam logic [AW-1:0] MMIO_START = 30'h4000000;
   localparam logic [AW-1:0] MMIO_LIMIT = 30'h40000FF;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [DAW-1:0] o_dmem_addr;
   logic [DW-1:0]  o_dmem_data;
   logic [MW-1:0]  o_dmem_mask;
   logic           o_dmem_wren;
   logic [DW-1:0]  dmem_rd = '0;
   logic           o_mmio_req;
   logic [AW-1:0]  o_mmio_addr;
   logic [DW-1:0]  o_mmio_data;
   logic [MW-1:0]  o_mmio_mask;
   logic           o_mmio_wren;
   logic           i_mmio_ready = 1'b0;
   logic [DW-1:0]  i_mmio_data = '0;

   mem_xbar_arb_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_xbar_arb #(
      .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_ADDR_WIDTH(DAW),
      .DATA_START(DATA_START), .DATA_LIMIT(DATA_LIMIT),
      .MMIO_START(MMIO_START), .MMIO_LIMIT(MMIO_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .o_dmem_addr(o_dmem_addr), .o_dmem_data(o_dmem_data), .o_dmem_mask(o_dmem_mask),
      .o_dmem_wren(o_dmem_wren), .i_dmem_data(dmem_rd),
      .o_mmio_req(o_mmio_req), .o_mmio_addr(o_mmio_addr), .o_mmio_data(o_mmio_data),
      .o_mmio_mask(o_mmio_mask), .o_mmio_wren(o_mmio_wren),
      .i_mmio_ready(i_mmio_ready), .i_mmio_data(i_mmio_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return (i == 5) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234);
   endfunction

   // Data memory device: synchronous read, byte-masked write, self-loading on first edge.
   logic [31:0] dmem_arr [1024];
   bit          dmem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!dmem_loaded) begin
         for (int i = 0; i < 1024; i++) dmem_arr[i] = init_word(i);
         dmem_loaded = 1'b1;
      end
      dmem_rd <= dmem_arr[o_dmem_addr];
      if (o_dmem_wren)
         for (int b = 0; b < MW; b++)
            if (o_dmem_mask[b]) dmem_arr[o_dmem_addr][8*b +: 8] = o_dmem_data[8*b +: 8];
   end

   logic [31:0]   ref_mem [1024];
   int            ref_ptr;
   logic          m_req  [NM];
   logic [AW-1:0] m_addr [NM];
   logic [DW-1:0] m_data [NM];
   logic [MW-1:0] m_mask [NM];
   logic          m_wren [NM];
   int            checks = 0;
   int            errors = 0;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus();
      for (int m = 0; m < NM; m++) begin
         bus.i_m_req[m]              = m_req[m];
         bus.i_m_addr[m*AW +: AW]    = m_addr[m];
         bus.i_m_data[m*DW +: DW]    = m_data[m];
         bus.i_m_mask[m*MW +: MW]    = m_mask[m];
         bus.i_m_wren[m]             = m_wren[m];
      end
   endtask

   task automatic set_master(input int m, input logic req, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [MW-1:0] mask, input logic wren);
      m_req[m]  = req;
      m_addr[m] = addr;
      m_data[m] = data;
      m_mask[m] = mask;
      m_wren[m] = wren;
      apply_stimulus();
   endtask

   function automatic int ref_winner();
      for (int k = 0; k < NM; k++)
         if (m_req[(ref_ptr + k) % NM]) return (ref_ptr + k) % NM;
      return -1;
   endfunction

   // 0 = data memory, 1 = MMIO, 2 = decode error; data memory wins any overlap.
   function automatic int classify(input logic [AW-1:0] a);
      if (int'(a) >= int'(DATA_START) && int'(a) <= int'(DATA_LIMIT)) return 0;
      if (int'(a) >= int'(MMIO_START) && int'(a) <= int'(MMIO_LIMIT)) return 1;
      return 2;
   endfunction

   // One arbitration round starting at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
   task automatic serve(input int stalls);
      int            w, cls;
      logic [AW-1:0] a;
      logic [9:0]    idx;
      logic [31:0]   exp_rd, mrd;
      @(negedge clk);
      w = ref_winner();
      if (w < 0) begin
         check_output("idle_gnt", 64'(bus.o_m_gnt), 64'd0);
         check_output("idle_dmem_wren", 64'(o_dmem_wren), 64'd0);
         @(posedge clk); #1;
         return;
      end
      a   = m_addr[w];
      cls = classify(a);
      idx = 10'(a - DATA_START);
      check_output("gnt", 64'(bus.o_m_gnt), 64'(1) << w);
      check_output("grant_mmio_req", 64'(o_mmio_req), 64'd0);
      if (cls == 0) begin
         check_output("dmem_wren", 64'(o_dmem_wren), 64'(m_wren[w]));
         check_output("dmem_addr", 64'(o_dmem_addr), 64'(idx));
         check_output("dmem_mask", 64'(o_dmem_mask), 64'(m_mask[w]));
         check_output("dmem_data", 64'(o_dmem_data), 64'(m_data[w]));
      end else begin
         check_output("no_dmem_wren", 64'(o_dmem_wren), 64'd0);
      end
      ref_ptr = (w + 1) % NM;
      @(posedge clk); #1;
      m_req[w] = 1'b0;
      apply_stimulus();
      if (cls == 0) begin
         @(negedge clk);
         exp_rd = m_wren[w] ? 32'd0 : ref_mem[idx];
         check_output("dmem_rvalid", 64'(bus.o_m_rvalid), 64'(1) << w);
         check_output("dmem_err", 64'(bus.o_m_err), 64'd0);
         check_output("dmem_rdata", 64'(bus.o_m_rdata), 64'(exp_rd));
         check_output("busy_gnt", 64'(bus.o_m_gnt), 64'd0);
         if (m_wren[w])
            for (int b = 0; b < MW; b++)
               if (m_mask[w][b]) ref_mem[idx][8*b +: 8] = m_data[w][8*b +: 8];
         @(posedge clk); #1;
      end else if (cls == 1) begin
         for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            check_output("mmio_req_wait", 64'(o_mmio_req), 64'd1);
            check_output("mmio_addr_wait", 64'(o_mmio_addr), 64'(a - MMIO_START));
            check_output("mmio_rvalid_wait", 64'(bus.o_m_rvalid), 64'd0);
            check_output("busy_gnt", 64'(bus.o_m_gnt), 64'd0);
            @(posedge clk); #1;
         end
         mrd          = $urandom;
         i_mmio_ready = 1'b1;
         i_mmio_data  = mrd;
         @(negedge clk);
         check_output("mmio_req", 64'(o_mmio_req), 64'd1);
         check_output("mmio_addr", 64'(o_mmio_addr), 64'(a - MMIO_START));
         check_output("mmio_wren", 64'(o_mmio_wren), 64'(m_wren[w]));
         check_output("mmio_data", 64'(o_mmio_data), 64'(m_data[w]));
         check_output("mmio_mask", 64'(o_mmio_mask), 64'(m_mask[w]));
         check_output("mmio_rvalid", 64'(bus.o_m_rvalid), 64'(1) << w);
         check_output("mmio_err", 64'(bus.o_m_err), 64'd0);
         check_output("mmio_rdata", 64'(bus.o_m_rdata), 64'(m_wren[w] ? 32'd0 : mrd));
         @(posedge clk); #1;
         i_mmio_ready = 1'b0;
         i_mmio_data  = '0;
      end else begin
         @(negedge clk);
         check_output("err_rvalid", 64'(bus.o_m_rvalid), 64'(1) << w);
         check_output("err_flag", 64'(bus.o_m_err), 64'd1);
         check_output("err_rdata", 64'(bus.o_m_rdata), 64'd0);
         check_output("err_no_dmem", 64'(o_dmem_wren), 64'd0);
         check_output("err_no_mmio", 64'(o_mmio_req), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic new_request(input int m);
      int            r;
      logic [AW-1:0] a;
      r = $urandom_range(0, 9);
      case (r)
         0, 1, 2, 3, 4: a = 30'($urandom_range(0, 1023));
         5:             a = DATA_LIMIT;
         6:             a = MMIO_START + 30'($urandom_range(0, 255));
         7:             a = MMIO_LIMIT;
         8:             a = MMIO_START - 30'd1;
         default:       a = DATA_LIMIT + 30'd1 + 30'($urandom_range(0, 1000));
      endcase
      set_master(m, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      int w;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      ref_ptr = 0;
      for (int m = 0; m < NM; m++) set_master(m, 1'b0, '0, '0, '0, 1'b0);

      $display("[TB] reset behaviour");
      set_master(0, 1'b1, 30'h5, '0, '0, 1'b0);
      @(negedge clk);
      check_output("reset_gnt", 64'(bus.o_m_gnt), 64'd0);
      check_output("reset_rvalid", 64'(bus.o_m_rvalid), 64'd0);
      check_output("reset_mmio_req", 64'(o_mmio_req), 64'd0);
      check_output("reset_dmem_wren", 64'(o_dmem_wren), 64'd0);
      check_output("reset_rdata", 64'(bus.o_m_rdata), 64'd0);
      m_req[0] = 1'b0;
      apply_stimulus();
      @(posedge clk); #1;
      rst_n = 1'b1;
      serve(0);

      $display("[TB] dmem read and masked write");
      set_master(0, 1'b1, 30'h5, '0, 4'hF, 1'b0);
      serve(0);
      set_master(1, 1'b1, 30'h10, 32'h11223344, 4'b0011, 1'b1);
      serve(0);
      set_master(1, 1'b1, 30'h10, '0, 4'hF, 1'b0);
      serve(0);

      $display("[TB] round robin");
      for (int i = 0; i < 4; i++) begin
         for (int m = 0; m < NM; m++)
            if (!m_req[m]) set_master(m, 1'b1, 30'(16 + 4*i + m), $urandom, 4'hF, 1'b0);
         serve(0);
      end
      set_master(0, 1'b1, 30'h20, '0, 4'hF, 1'b0);
      serve(0);
      set_master(0, 1'b1, 30'h21, '0, 4'hF, 1'b0);
      serve(0);

      $display("[TB] mmio wait states and decode errors");
      set_master(0, 1'b1, MMIO_START + 30'd3, '0, 4'hF, 1'b0);
      serve(3);
      set_master(1, 1'b1, MMIO_START + 30'h40, $urandom, 4'b1010, 1'b1);
      serve(1);
      set_master(0, 1'b1, 30'h2000000, '0, 4'hF, 1'b0);
      serve(0);
      set_master(1, 1'b1, 30'h2000000, $urandom, 4'hF, 1'b1);
      serve(0);

      $display("[TB] random traffic");
      for (int it = 0; it < 80; it++) begin
         for (int m = 0; m < NM; m++)
            if (!m_req[m] && $urandom_range(0, 3) != 0) new_request(m);
         serve($urandom_range(0, 3));
      end

      $display("[TB] reset during mmio wait");
      for (int m = 0; m < NM; m++) m_req[m] = 1'b0;
      apply_stimulus();
      set_master(0, 1'b1, MMIO_START + 30'h10, '0, 4'hF, 1'b0);
      @(negedge clk);
      w = ref_winner();
      check_output("rst_mid_gnt", 64'(bus.o_m_gnt), 64'(1) << w);
      @(posedge clk); #1;
      m_req[0] = 1'b0;
      apply_stimulus();
      @(negedge clk);
      check_output("rst_mid_mmio_req_before", 64'(o_mmio_req), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_output("rst_mid_mmio_req_after", 64'(o_mmio_req), 64'd0);
      check_output("rst_mid_rvalid", 64'(bus.o_m_rvalid), 64'd0);
      ref_ptr = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_master(1, 1'b1, 30'h5, '0, 4'hF, 1'b0);
      serve(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_xbar_arb.md
Name: mem_xbar_arb

Overview:
Parametrised successor to the single-master memory crossbar. It arbitrates NUM_MASTERS request ports (core load/store, DMA, debug) onto two slaves: data memory (synchronous read, 1-cycle latency) and an MMIO window with a ready handshake. Arbitration is round-robin and one transaction is in flight at a time. Addresses outside both windows get an error response. It sits between the cores/DMA and dmem/MMIO in the CPU top.

Parameters:
NUM_MASTERS, 2, number of master ports (1..8)
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, data width; mask width = DATA_WIDTH/8
DMEM_ADDR_WIDTH, 10, dmem word address width
DATA_START, 30'h0, first dmem word address (inclusive)
DATA_LIMIT, 30'h3FF, last dmem word address (inclusive)
MMIO_START, 30'h4000000, first MMIO word address (inclusive)
MMIO_LIMIT, 30'h40000FF, last MMIO word address (inclusive)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
i_m_req  in  NUM_MASTERS  per-master request
i_m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master word address, packed with master 0 in the LSBs
i_m_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data
i_m_mask  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte mask
i_m_wren  in  NUM_MASTERS  per-master write enable
o_m_gnt  out  NUM_MASTERS  one-hot grant; request accepted this cycle
o_m_rvalid  out  NUM_MASTERS  one-hot response valid (read data or write ack)
o_m_err  out  1  response is a decode error; qualified by any o_m_rvalid
o_m_rdata  out  DATA_WIDTH  response read data, shared
o_dmem_addr  out  DMEM_ADDR_WIDTH  dmem word address (addr - DATA_START)
o_dmem_data  out  DATA_WIDTH  dmem write data
o_dmem_mask  out  DATA_WIDTH/8  dmem byte mask
o_dmem_wren  out  1  dmem write strobe
i_dmem_data  in  DATA_WIDTH  dmem read data; valid the cycle after the address
o_mmio_req  out  1  MMIO request
o_mmio_addr  out  ADDR_WIDTH  MMIO word address (addr - MMIO_START)
o_mmio_data  out  DATA_WIDTH  MMIO write data
o_mmio_mask  out  DATA_WIDTH/8  MMIO byte mask
o_mmio_wren  out  1  MMIO write enable; qualified by o_mmio_req
i_mmio_ready  in  1  MMIO completes this cycle
i_mmio_data  in  DATA_WIDTH  MMIO read data; valid with i_mmio_ready

Behaviour:
- Reset (asynchronous assert): state=IDLE, rr_ptr=0, all outputs 0. Reset during any state aborts the transaction; no response is issued and o_mmio_req drops immediately.
- States: IDLE, DMEM_RESP, MMIO_WAIT, ERR_RESP.
- IDLE: the winner is the first master with i_m_req=1, searching upward from rr_ptr with wrap.
  - o_m_gnt[winner]=1 combinationally in the same cycle.
  - Winner id, address, data, mask and wren are latched.
  - After the grant, rr_ptr = winner+1 mod NUM_MASTERS.
  - Decode uses inclusive bounds; the DATA window takes priority if the windows overlap.
  - DATA window: o_dmem_addr/data/mask are driven combinationally from the winner; o_dmem_wren = winner wren, grant cycle only. Next state DMEM_RESP.
  - MMIO window: next state MMIO_WAIT.
  - Neither window: next state ERR_RESP; no slave is touched.
  - No request: stay IDLE; o_m_gnt=0 and o_dmem_wren=0.
- DMEM_RESP, 1 cycle: o_m_rvalid[id]=1, o_m_rdata=i_dmem_data (reads) or 0 (writes), o_m_err=0. Next state IDLE.
- MMIO_WAIT:
  - o_mmio_req=1; o_mmio_addr/data/mask/wren come from latched registers and are held stable.
  - When i_mmio_ready=1: o_m_rvalid[id]=1, o_m_rdata=i_mmio_data (reads) or 0 (writes), o_mmio_req drops next cycle, next state IDLE.
  - No timeout.
- ERR_RESP, 1 cycle: o_m_rvalid[id]=1, o_m_err=1, o_m_rdata=0. Next state IDLE.
- Outside valid response cycles, o_m_rdata=0 and o_m_err=0.
- Throughput: at most one grant every 2 cycles; no grants outside IDLE.
- Master rules:
  - A master holds req/addr/data/mask/wren stable until it sees gnt.
  - A master may drop req or issue a new request after gnt.
  - Requests not granted remain pending with no side effects.
- Address offset subtraction is truncated to the slave address width.

Test Plan:
- Read dmem: master 0 reads addr 0x5, dmem word 5=0xDEADBEEF -> gnt[0] in cycle N, rvalid[0] with rdata=0xDEADBEEF in cycle N+1, err=0.
- Masked write: master 1 writes 0x11223344 with mask 4'b0011 to 0x10 -> o_dmem_wren=1 for one cycle, o_dmem_addr=0x10, mask 0011, rvalid[1] next cycle; readback gives the low half updated.
- Round-robin: both masters request continuously -> grants alternate 0,1,0,1 every 2 cycles; with rr_ptr=1 and only master 0 requesting, master 0 is granted.
- MMIO wait states: master 0 reads MMIO_START+3 while i_mmio_ready is held low for 3 cycles -> o_mmio_req high 4 cycles, o_mmio_addr=3 stable throughout, rvalid[0] with rdata=i_mmio_data on the ready cycle.
- Decode error: address 0x2000000 -> gnt, then rvalid with err=1 and rdata=0 next cycle; no dmem or MMIO strobe.
- Reset mid-MMIO: assert rst_n=0 in MMIO_WAIT -> o_mmio_req=0 immediately, no rvalid; after release, a master 1 request is granted first (rr_ptr=0, only master 1 requesting).
